// File: rtl/pipe_stage_reg.sv
// Parametrised pipeline stage register: valid/ready handshake, flush, bubble zeroing, saturating stall counter.
// Define PIPE_STAGE_SKID_EN to build the two-entry skid buffer with a registered o_ready.
module pipe_stage_reg #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 5,
  parameter int CNT_W  = 16
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [CTRL_W-1:0] i_ctrl,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_flush,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [CTRL_W-1:0] o_ctrl,
  output logic [DATA_W-1:0] o_data,
  output logic [CNT_W-1:0]  o_stall_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic up_xfer;
  logic dn_xfer;

  assign up_xfer = i_valid & o_ready;
  assign dn_xfer = o_valid & i_ready;

  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      o_stall_cnt <= '0;
    end else if (o_valid && !i_ready && (o_stall_cnt != CNT_MAX)) begin
      o_stall_cnt <= o_stall_cnt + 1'b1;
    end
  end

`ifdef PIPE_STAGE_SKID_EN

  typedef enum logic [1:0] {
    EMPTY,
    ONE,
    TWO
  } state_t;

  state_t            state;
  logic              ready_q;
  logic [CTRL_W-1:0] skid_ctrl;
  logic [DATA_W-1:0] skid_data;

  assign o_ready = ready_q;

  // Head holds the older entry; the skid register only ever holds the younger one.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      // NOTE: payload registers are reset as well, so o_data reads 0 straight out of reset.
      state     <= EMPTY;
      ready_q   <= 1'b1;
      o_valid   <= 1'b0;
      o_ctrl    <= '0;
      o_data    <= '0;
      skid_ctrl <= '0;
      skid_data <= '0;
    end else if (i_flush) begin
      state   <= EMPTY;
      ready_q <= 1'b1;
      o_valid <= 1'b0;
      o_ctrl  <= '0;
    end else begin
      case (state)
        EMPTY: begin
          if (up_xfer) begin
            o_valid <= 1'b1;
            o_ctrl  <= i_ctrl;
            o_data  <= i_data;
            state   <= ONE;
          end
        end
        ONE: begin
          if (up_xfer && !dn_xfer) begin
            skid_ctrl <= i_ctrl;
            skid_data <= i_data;
            state     <= TWO;
            ready_q   <= 1'b0;
          end else if (up_xfer && dn_xfer) begin
            o_ctrl <= i_ctrl;
            o_data <= i_data;
          end else if (dn_xfer) begin
            o_valid <= 1'b0;
            o_ctrl  <= '0;
            state   <= EMPTY;
          end
        end
        TWO: begin
          if (dn_xfer) begin
            o_ctrl  <= skid_ctrl;
            o_data  <= skid_data;
            state   <= ONE;
            ready_q <= 1'b1;
          end
        end
        default: begin
          state   <= EMPTY;
          ready_q <= 1'b1;
          o_valid <= 1'b0;
          o_ctrl  <= '0;
        end
      endcase
    end
  end

`else

  assign o_ready = !o_valid | i_ready;

  // A simultaneous upstream beat replaces the departing one, so no bubble on back-to-back traffic.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      o_valid <= 1'b0;
      o_ctrl  <= '0;
      o_data  <= '0;
    end else if (i_flush) begin
      o_valid <= 1'b0;
      o_ctrl  <= '0;
    end else if (up_xfer) begin
      o_valid <= 1'b1;
      o_ctrl  <= i_ctrl;
      o_data  <= i_data;
    end else if (dn_xfer) begin
      o_valid <= 1'b0;
      o_ctrl  <= '0;
    end
  end

`endif

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Generic, parametrised pipeline stage register that replaces the fixed per-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB) of the CPU datapath. It adds a valid/ready handshake, synchronous flush, and bubble insertion that zeroes control bits. It also has a saturating stall counter for performance monitoring. An optional two-entry skid buffer lets the stage sustain full throughput with a registered `o_ready`.

## Interface
Parameters:
- `DATA_W`, 32: payload width. Payload is never cleared except by reset.
- `CTRL_W`, 5: control-bit width (Branch, MemRead, MemWrite, RegWrite, MemToReg, …). Forced to 0 on any bubble.
- `CNT_W`, 16: stall counter width.

Ports:
- `i_clk`, input, 1: clock. All state updates on the rising edge.
- `i_reset`, input, 1: reset, asynchronous, active-high.
- `i_valid`, input, 1: upstream has a valid entry.
- `o_ready`, output, 1: stage can accept this cycle.
- `i_ctrl`, input, CTRL_W: upstream control bits.
- `i_data`, input, DATA_W: upstream payload (ALU result, addresses, Rd, …).
- `i_flush`, input, 1: synchronous flush (branch taken / exception).
- `o_valid`, output, 1: stage holds a valid entry.
- `i_ready`, input, 1: downstream accepts this cycle.
- `o_ctrl`, output, CTRL_W: control bits. Always 0 when `o_valid`=0.
- `o_data`, output, DATA_W: payload of the head entry.
- `o_stall_cnt`, output, CNT_W: cycles with `o_valid`=1 and `i_ready`=0.

## Operation
- **Reset values:** `o_valid`=0, `o_ctrl`=0, `o_data`=0, `o_stall_cnt`=0, skid entry empty.
- **Handshakes:**
  - Upstream transfer = `i_valid & o_ready`.
  - Downstream transfer = `o_valid & i_ready`.
  - `o_valid`, `o_ctrl` and `o_data` stay stable while `o_valid & !i_ready`.
- **Base mode (macro undefined):**
  - `o_ready = !o_valid | i_ready`. This is a combinational path from `i_ready`.
  - On an upstream transfer, the entry loads `i_ctrl`/`i_data` and sets `o_valid`=1.
  - On a downstream transfer with no upstream transfer, `o_valid`←0 and `o_ctrl`←0. `o_data` holds its value.
  - When both transfers happen in the same cycle, the new entry replaces the old one (back-to-back, no bubble).
- **Flush:**
  - Takes priority over every other event.
  - Next cycle: `o_valid`=0, `o_ctrl`=0, skid entry empty.
  - Any upstream beat in the flush cycle is discarded, even if `o_ready`=1.
  - `o_data` and `o_stall_cnt` are unaffected.
- **Stall counter:**
  - Increments each cycle with `o_valid & !i_ready`, including the flush cycle.
  - Saturates at 2^CNT_W−1. No wrap.
  - Cleared only by reset.
- **Bubble rule:** whenever the next `o_valid` is 0, the registered `o_ctrl` is loaded with 0. Downstream logic therefore never sees stale MemWrite/RegWrite.

## Timing
- Latency is 1 cycle: a beat accepted at edge N appears on `o_valid`/`o_ctrl`/`o_data` after edge N.
- Base mode throughput is 1 beat/cycle.
- Base mode combinational paths: `i_ready`→`o_ready` only. No path from `i_valid` or `i_flush` to any output.
- Skid mode:
  - `o_ready` is registered. No combinational input→output path.
  - Throughput is 1 beat/cycle, latency is still 1 cycle.
- Reset asserted mid-transfer takes effect immediately (asynchronous). Any held entries are lost.
- First accept is possible on the first edge after `i_reset` deasserts.

## Configuration
- Macro: `PIPE_STAGE_SKID_EN`.
- **Undefined:** single-entry stage as described under base mode.
- **Defined:** a two-entry skid buffer with a state machine.
  - States: EMPTY, ONE, TWO. `o_ready` = (state != TWO), registered.
  - EMPTY→ONE on an upstream transfer.
  - ONE→TWO on an upstream transfer without a downstream transfer. The new beat goes into the skid register.
  - ONE→EMPTY on a downstream transfer without an upstream transfer.
  - ONE→ONE when both transfers occur.
  - TWO→ONE on a downstream transfer. The skid entry moves to the head. No upstream transfer is possible because `o_ready`=0.
  - Any state→EMPTY on `i_flush`.
  - Order is preserved: the head is always the older entry.

## Test plan
- **Reset:** assert `i_reset` mid-stream with `o_valid`=1, `o_ctrl`=5'h1F, `o_data`=32'hDEADBEEF → all outputs read 0 immediately, before the next edge.
- **Streaming:** `i_ready`=1, `i_valid`=1 for 4 cycles with data 1,2,3,4 → `o_data` is 1,2,3,4 on consecutive cycles, each one cycle late; `o_stall_cnt`=0.
- **Backpressure:** `i_ready`=0 for 3 cycles with `o_valid`=1 and data 32'hA5 → data held, `o_stall_cnt`=3.
  - With the macro defined: the second beat (32'h5A) is accepted, then `o_ready`=0; after release, outputs are A5 then 5A.
- **Flush:** `i_flush`=1 with `o_valid`=1, `o_ctrl`=5'b00110, and `i_valid`=1 (data 7) in the same cycle → next cycle `o_valid`=0, `o_ctrl`=0, beat 7 never appears.
- **Bubble:** `i_valid`=0 after a beat with `o_ctrl`=5'b01010 is consumed → `o_ctrl`=0 next cycle, `o_data` unchanged.
- **Saturation:** with CNT_W=4, hold stalled for 20 cycles → `o_stall_cnt` stops at 15.
